// File: rtl/mem_bus_pkg.sv
// Shared types for the fetch/mem-stage memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWNER_INSTR, OWNER_DATA} owner_t;

  localparam logic [63:0] BUS_ERROR_READ_VALUE = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single 64-bit memory bus between instruction fetch and data ports,
// one transaction at a time, with starvation guard and bus timeout abort.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_read_in,
  input  logic [63:0] instr_address_in,
  output logic        instr_ready_out,
  output logic [63:0] instr_read_value_out,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [63:0] data_address_in,
  input  logic [63:0] data_write_value_in,
  input  logic [7:0]  data_write_mask_in,
  output logic        data_ready_out,
  output logic [63:0] data_read_value_out,
  output logic        bus_valid_out,
  output logic        bus_write_out,
  output logic [63:0] bus_address_out,
  output logic [63:0] bus_write_value_out,
  output logic [7:0]  bus_write_mask_out,
  input  logic        bus_ready_in,
  input  logic [63:0] bus_read_value_in,
  output logic        bus_error_out
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [7:0]    WAIT_MAX   = 8'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state, state_nx;
  owner_t        owner;
  bus_req_t      bus_q;
  logic [7:0]    wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic          data_req, grant_data, grant_instr, timeout, done;
  logic [63:0]   capture_value;

  assign data_req      = data_read_in | data_write_in;
  assign grant_data    = data_req && !(instr_read_in && starve_cnt == STARVE_MAX);
  assign grant_instr   = instr_read_in && !grant_data;
  assign timeout       = (wait_cnt == WAIT_MAX) && !bus_ready_in;
  assign done          = bus_ready_in || timeout;
  assign capture_value = bus_ready_in ? bus_read_value_in : BUS_ERROR_READ_VALUE;

  assign bus_write_out       = bus_q.wr;
  assign bus_address_out     = bus_q.addr;
  assign bus_write_value_out = bus_q.wdata;
  assign bus_write_mask_out  = bus_q.mask;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_data || grant_instr) state_nx = BUSY;
      BUSY:    if (done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner                <= OWNER_INSTR;
      bus_q                <= '0;
      bus_valid_out        <= 1'b0;
      bus_error_out        <= 1'b0;
      instr_ready_out      <= 1'b0;
      data_ready_out       <= 1'b0;
      instr_read_value_out <= '0;
      data_read_value_out  <= '0;
      wait_cnt             <= '0;
      starve_cnt           <= '0;
    end else begin
      instr_ready_out <= 1'b0;
      data_ready_out  <= 1'b0;
      bus_error_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            owner         <= OWNER_DATA;
            bus_valid_out <= 1'b1;
            wait_cnt      <= '0;
            bus_q <= '{wr: data_write_in, addr: data_address_in, wdata: data_write_value_in,
                       mask: data_write_in ? data_write_mask_in : 8'h00};
            // only data grants that bypass a waiting fetch count toward starvation
            if (!instr_read_in)                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
          end else if (grant_instr) begin
            owner         <= OWNER_INSTR;
            bus_valid_out <= 1'b1;
            wait_cnt      <= '0;
            starve_cnt    <= '0;
            bus_q <= '{wr: 1'b0, addr: instr_address_in, wdata: 64'h0, mask: 8'h00};
          end
        end
        BUSY: begin
          if (done) begin
            bus_valid_out <= 1'b0;
            bus_error_out <= !bus_ready_in;
            if (owner == OWNER_DATA) data_ready_out  <= 1'b1;
            else                     instr_ready_out <= 1'b1;
            if (!bus_q.wr) begin
              if (owner == OWNER_DATA) data_read_value_out  <= capture_value;
              else                     instr_read_value_out <= capture_value;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter with a behavioural bus slave.
module tb_mem_bus_arbiter;
  localparam int TMO = 8;
  localparam int STV = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        instr_read_in = 1'b0;
  logic [63:0] instr_address_in = '0;
  logic        instr_ready_out;
  logic [63:0] instr_read_value_out;
  logic        data_read_in = 1'b0, data_write_in = 1'b0;
  logic [63:0] data_address_in = '0, data_write_value_in = '0;
  logic [7:0]  data_write_mask_in = '0;
  logic        data_ready_out;
  logic [63:0] data_read_value_out;
  logic        bus_valid_out, bus_write_out, bus_error_out;
  logic [63:0] bus_address_out, bus_write_value_out;
  logic [7:0]  bus_write_mask_out;
  logic        bus_ready_in = 1'b0;
  logic [63:0] bus_read_value_in = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(STV)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_read_in(instr_read_in), .instr_address_in(instr_address_in),
    .instr_ready_out(instr_ready_out), .instr_read_value_out(instr_read_value_out),
    .data_read_in(data_read_in), .data_write_in(data_write_in),
    .data_address_in(data_address_in), .data_write_value_in(data_write_value_in),
    .data_write_mask_in(data_write_mask_in), .data_ready_out(data_ready_out),
    .data_read_value_out(data_read_value_out),
    .bus_valid_out(bus_valid_out), .bus_write_out(bus_write_out),
    .bus_address_out(bus_address_out), .bus_write_value_out(bus_write_value_out),
    .bus_write_mask_out(bus_write_mask_out), .bus_ready_in(bus_ready_in),
    .bus_read_value_in(bus_read_value_in), .bus_error_out(bus_error_out)
  );

  typedef struct {logic [63:0] val; logic err; int cyc;} done_t;
  typedef struct {logic [63:0] val; logic err;} exp_t;
  typedef struct {logic w; logic [63:0] addr; logic [63:0] wd; logic [7:0] mask;} dreq_t;
  typedef struct {logic w; logic [63:0] addr; logic [7:0] mask; int cyc;} grant_t;

  int total = 0, bad = 0, cyc = 0, unstable = 0, orphan = 0, valid_cycles = 0;
  int mem_wait = 0, wcnt = 0;
  bit mem_never = 0;
  done_t  done_i[$], done_d[$];
  exp_t   exp_i[$], exp_d[$];
  logic [63:0] iq[$];
  dreq_t  dq[$];
  grant_t glog[$];
  logic [63:0] mem[logic [63:0]];
  logic [63:0] shadow[logic [63:0]];
  logic [63:0] last_d = '0;
  logic        prev_valid = 1'b0;
  logic [136:0] prev_fields = '0;

  function automatic logic [63:0] init_val(logic [63:0] a);
    return {a[31:0], ~a[31:0]};
  endfunction
  function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] n, logic [7:0] m);
    logic [63:0] r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction
  function automatic logic [63:0] mem_rd(logic [63:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [63:0] shadow_rd(logic [63:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction
  function automatic int gcyc(int i);
    return (glog.size() > i) ? glog[i].cyc : -1000;
  endfunction

  always @(posedge clk) cyc++;

  // bus slave: answers after mem_wait idle valid cycles, or never
  always @(negedge clk) begin
    if (bus_valid_out && !mem_never) begin
      if (wcnt >= mem_wait) begin
        bus_ready_in = 1'b1;
        if (bus_write_out) begin
          mem[bus_address_out] = merge(mem_rd(bus_address_out), bus_write_value_out, bus_write_mask_out);
          bus_read_value_in = 64'h0000_1234_5678_9ABC;
        end else begin
          bus_read_value_in = mem_rd(bus_address_out);
        end
        wcnt = 0;
      end else begin
        bus_ready_in = 1'b0;
        wcnt++;
      end
    end else begin
      bus_ready_in = 1'b0;
      wcnt = 0;
    end
  end

  // requesters: drop or replace the request on the ready pulse
  always @(negedge clk) begin
    dreq_t d;
    if (instr_ready_out) instr_read_in = 1'b0;
    if (!instr_read_in && iq.size() > 0) begin
      instr_address_in = iq.pop_front();
      instr_read_in = 1'b1;
    end
    if (data_ready_out) begin data_read_in = 1'b0; data_write_in = 1'b0; end
    if (!data_read_in && !data_write_in && dq.size() > 0) begin
      d = dq.pop_front();
      data_write_in = d.w; data_read_in = !d.w;
      data_address_in = d.addr; data_write_value_in = d.wd; data_write_mask_in = d.mask;
    end
  end

  always @(negedge clk) begin
    logic [136:0] f;
    f = {bus_write_out, bus_address_out, bus_write_value_out, bus_write_mask_out};
    if (instr_ready_out) done_i.push_back('{instr_read_value_out, bus_error_out, cyc});
    if (data_ready_out)  done_d.push_back('{data_read_value_out, bus_error_out, cyc});
    if (bus_error_out && !instr_ready_out && !data_ready_out) orphan++;
    if (bus_valid_out) valid_cycles++;
    if (bus_valid_out && !prev_valid) glog.push_back('{bus_write_out, bus_address_out, bus_write_mask_out, cyc});
    if (bus_valid_out && prev_valid && f != prev_fields) unstable++;
    prev_valid = bus_valid_out;
    prev_fields = f;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req_i(logic [63:0] a, bit tmo);
    exp_t e;
    e.val = tmo ? 64'hFFFF_FFFF_FFFF_FFFF : shadow_rd(a);
    e.err = tmo;
    exp_i.push_back(e);
    iq.push_back(a);
  endtask

  task automatic req_d(bit w, logic [63:0] a, logic [63:0] wd, logic [7:0] m);
    exp_t e;
    if (w) begin
      shadow[a] = merge(shadow_rd(a), wd, m);
      e.val = last_d;
    end else begin
      e.val = shadow_rd(a);
      last_d = e.val;
    end
    e.err = 1'b0;
    exp_d.push_back(e);
    dq.push_back('{w, a, wd, m});
  endtask

  task automatic settle(string tag, int ni, int nd, int budget);
    int n = 0;
    while ((done_i.size() < ni || done_d.size() < nd) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_icount"}, done_i.size(), ni);
    chk({tag, "_dcount"}, done_d.size(), nd);
  endtask

  task automatic pop_chk(string tag, bit is_data, output int rcyc);
    exp_t e; done_t d;
    rcyc = -1;
    if (is_data) begin
      if (done_d.size() == 0 || exp_d.size() == 0) return;
      e = exp_d.pop_front(); d = done_d.pop_front();
    end else begin
      if (done_i.size() == 0 || exp_i.size() == 0) return;
      e = exp_i.pop_front(); d = done_i.pop_front();
    end
    chk({tag, "_val"}, d.val, e.val);
    chk({tag, "_err"}, d.err, e.err);
    rcyc = d.cyc;
  endtask

  task automatic chk_grant(string tag, int i, logic w, logic [63:0] a, logic [7:0] m);
    if (glog.size() <= i) begin
      chk({tag, "_present"}, glog.size(), i + 1);
      return;
    end
    chk({tag, "_w"}, glog[i].w, w);
    chk({tag, "_addr"}, glog[i].addr, a);
    chk({tag, "_mask"}, glog[i].mask, m);
  endtask

  initial begin
    int rc, rc2, vc0, n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", bus_valid_out, 1'b0);
    chk("rst_iready", instr_ready_out, 1'b0);
    chk("rst_dready", data_ready_out, 1'b0);
    chk("rst_err", bus_error_out, 1'b0);
    chk("rst_ival", instr_read_value_out, 64'h0);
    chk("rst_dval", data_read_value_out, 64'h0);
    chk("rst_bus", {bus_write_out, bus_address_out, bus_write_value_out, bus_write_mask_out}, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // single data read, zero memory wait
    mem[64'h1000] = 64'hDEAD_BEEF; shadow[64'h1000] = 64'hDEAD_BEEF;
    glog.delete();
    req_d(0, 64'h1000, 64'h0, 8'hFF);
    settle("t1", 0, 1, 20);
    pop_chk("t1", 1, rc);
    chk("t1_lat", rc - gcyc(0), 1);
    chk_grant("t1_g", 0, 0, 64'h1000, 8'h00);
    repeat (3) @(negedge clk);

    // simultaneous fetch and partial write: data first
    glog.delete();
    req_i(64'h4000, 0);
    req_d(1, 64'h3000, 64'h1122_3344_5566_7788, 8'h0F);
    settle("t2", 1, 1, 40);
    pop_chk("t2d", 1, rc);
    pop_chk("t2i", 0, rc2);
    chk_grant("t2_g0", 0, 1, 64'h3000, 8'h0F);
    chk_grant("t2_g1", 1, 0, 64'h4000, 8'h00);
    req_d(0, 64'h3000, 64'h0, 8'h00);
    settle("t2r", 0, 1, 20);
    pop_chk("t2r", 1, rc);
    repeat (3) @(negedge clk);

    // starvation guard
    glog.delete();
    for (int k = 0; k < 6; k++) req_d(0, 64'h5000 + 64'(8 * k), 64'h0, 8'h00);
    req_i(64'h6000, 0);
    settle("t3", 1, 6, 200);
    for (int k = 0; k < 6; k++) pop_chk($sformatf("t3d%0d", k), 1, rc);
    pop_chk("t3i", 0, rc);
    for (int k = 0; k < 7; k++)
      chk_grant($sformatf("t3_g%0d", k), k, 0,
                (k == 4) ? 64'h6000 : 64'h5000 + 64'(8 * ((k < 4) ? k : k - 1)), 8'h00);
    repeat (3) @(negedge clk);

    // bus timeout on a fetch
    mem_never = 1;
    glog.delete();
    vc0 = valid_cycles;
    req_i(64'h7000, 1);
    settle("t4", 1, 0, 60);
    pop_chk("t4", 0, rc);
    chk("t4_lat", rc - gcyc(0), TMO + 1);
    chk("t4_vcyc", valid_cycles - vc0, TMO + 1);
    repeat (3) @(negedge clk);

    // reset mid-BUSY after 3 wait cycles, then re-grant restarts the wait count
    glog.delete();
    req_i(64'h8000, 1);
    n = 0;
    while (glog.size() == 0 && n < 20) begin @(negedge clk); n++; end
    chk("t5_granted", glog.size(), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid_drop", bus_valid_out, 1'b0);
    chk("t5_ival_clr", instr_read_value_out, 64'h0);
    last_d = '0;
    repeat (2) @(negedge clk);
    glog.delete();
    vc0 = valid_cycles;
    rst_n = 1'b1;
    settle("t5", 1, 0, 60);
    pop_chk("t5", 0, rc);
    chk("t5_lat", rc - gcyc(0), TMO + 1);
    chk("t5_vcyc", valid_cycles - vc0, TMO + 1);
    chk_grant("t5_g", 0, 0, 64'h8000, 8'h00);
    mem_never = 0;
    repeat (3) @(negedge clk);

    // write then read with two memory wait cycles each
    mem_wait = 2;
    glog.delete();
    req_d(1, 64'h9000, 64'hCAFE_F00D_1234_5678, 8'hFF);
    req_d(0, 64'h9000, 64'h0, 8'h00);
    settle("t6", 0, 2, 60);
    pop_chk("t6w", 1, rc);
    chk("t6w_lat", rc - gcyc(0), 3);
    pop_chk("t6r", 1, rc);
    chk("t6r_lat", rc - gcyc(1), 3);
    repeat (3) @(negedge clk);

    chk("bus_stable", unstable, 0);
    chk("orphan_err", orphan, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
